// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the accumulator control unit: opcodes, ALU select
// encodings, FSM state encoding and instruction field positions.
package acc_ctrl_pkg;

  // Instruction word layout: [15:12] opcode, low bits operand address
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  // Opcodes (0xB-0xE are unused and behave as NOP)
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  // alu16b operation select
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_NOT   = 3'b101;
  localparam logic [2:0] ALU_PASS2 = 3'b110;
  localparam logic [2:0] ALU_PASS1 = 3'b111;

  // Multi-cycle sequencer states
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

endpackage

// File: rtl/acc_ctrl_decode.sv
// Combinational opcode decoder: classifies an opcode and picks the ALU select.
module acc_ctrl_decode
  import acc_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] alu_sel,
  output logic       uses_mem,
  output logic       is_alu,
  output logic       is_store,
  output logic       is_load,
  output logic       is_jump,
  output logic       is_halt
);

  // Opcode classification; anything not listed falls through as a NOP
  always_comb begin
    alu_sel  = ALU_PASS1;
    uses_mem = 1'b0;
    is_alu   = 1'b0;
    is_store = 1'b0;
    is_load  = 1'b0;
    is_jump  = 1'b0;
    is_halt  = 1'b0;
    case (opcode)
      OP_LDA: begin uses_mem = 1'b1; is_load  = 1'b1; end
      OP_STA: begin uses_mem = 1'b1; is_store = 1'b1; end
      OP_ADD: begin uses_mem = 1'b1; is_alu = 1'b1; alu_sel = ALU_ADD; end
      OP_SUB: begin uses_mem = 1'b1; is_alu = 1'b1; alu_sel = ALU_SUB; end
      OP_AND: begin uses_mem = 1'b1; is_alu = 1'b1; alu_sel = ALU_AND; end
      OP_OR:  begin uses_mem = 1'b1; is_alu = 1'b1; alu_sel = ALU_OR;  end
      OP_XOR: begin uses_mem = 1'b1; is_alu = 1'b1; alu_sel = ALU_XOR; end
      OP_NOT: begin is_alu = 1'b1; alu_sel = ALU_NOT; end
      OP_JMP: is_jump = 1'b1;
      OP_JZ:  is_jump = 1'b1;
      OP_HLT: is_halt = 1'b1;
      default: alu_sel = ALU_PASS1;
    endcase
  end

endmodule

// File: rtl/acc_ctrl_unit.sv
// Multi-cycle control unit for the accumulator processor. Owns PC, IR, ACC
// and Z, sequences fetch/decode/memory/execute/write-back, and drives the
// instruction memory, data memory and alu16b from registered outputs.
module acc_ctrl_unit
  import acc_ctrl_pkg::*;
#(
  parameter int             AW       = 8,
  parameter logic [AW-1:0]  RESET_PC = {AW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic [AW-1:0] imem_addr,
  input  logic [15:0]   imem_rdata,
  output logic [AW-1:0] dmem_addr,
  output logic [15:0]   dmem_wdata,
  output logic          dmem_we,
  input  logic [15:0]   dmem_rdata,
  output logic [15:0]   alu_in1,
  output logic [15:0]   alu_in2,
  output logic [2:0]    alu_sel,
  input  logic [15:0]   alu_out,
  input  logic          alu_zf,
  output logic [15:0]   acc,
  output logic [AW-1:0] pc,
  output logic          halted
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, pc_inc;
  logic [15:0]   ir_q, ir_d;
  logic [15:0]   acc_q, acc_d;
  logic          z_q, z_d;
  logic          halted_q, halted_d;
  logic [AW-1:0] imem_addr_q, imem_addr_d;
  logic [AW-1:0] dmem_addr_q, dmem_addr_d;
  logic [15:0]   dmem_wdata_q, dmem_wdata_d;
  logic          dmem_we_q, dmem_we_d;
  logic [15:0]   alu_in1_q, alu_in1_d;
  logic [15:0]   alu_in2_q, alu_in2_d;
  logic [2:0]    alu_sel_q, alu_sel_d;

  logic [3:0]    dec_opcode;
  logic [2:0]    dec_alu_sel;
  logic          dec_uses_mem, dec_is_alu, dec_is_store, dec_is_load;
  logic          dec_is_jump, dec_is_halt;
  logic          unused_ir;

  // The operand is consumed straight from imem_rdata in DECODE, so the
  // stored copy of the low IR bits is kept only for architectural visibility.
  assign unused_ir = ^ir_q[11:0];
  assign pc_inc    = pc_q + {{(AW-1){1'b0}}, 1'b1};

  // The fresh instruction word is only on imem_rdata during DECODE; later
  // states decode the latched IR.
  always_comb begin
    if (state_q == ST_DECODE) begin
      dec_opcode = imem_rdata[OPC_MSB:OPC_LSB];
    end else begin
      dec_opcode = ir_q[OPC_MSB:OPC_LSB];
    end
  end

  acc_ctrl_decode u_decode (
    .opcode   (dec_opcode),
    .alu_sel  (dec_alu_sel),
    .uses_mem (dec_uses_mem),
    .is_alu   (dec_is_alu),
    .is_store (dec_is_store),
    .is_load  (dec_is_load),
    .is_jump  (dec_is_jump),
    .is_halt  (dec_is_halt)
  );

  // Next-state and datapath update; every register holds unless its state acts
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    acc_d        = acc_q;
    z_d          = z_q;
    halted_d     = halted_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_we_d    = 1'b0;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    alu_sel_d    = alu_sel_q;
    case (state_q)
      ST_FETCH: begin
        if (run) begin
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        ir_d = imem_rdata;
        pc_d = pc_inc;
        if (dec_is_halt) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else if (dec_is_jump) begin
          if ((dec_opcode == OP_JMP) || z_q) begin
            pc_d = imem_rdata[AW-1:0];
          end else begin
            pc_d = pc_inc;
          end
          state_d = ST_FETCH;
        end else if (dec_uses_mem) begin
          // Address and store strobe are registered here so they are
          // presented to the data memory for the whole MEM cycle.
          dmem_addr_d  = imem_rdata[AW-1:0];
          dmem_wdata_d = acc_q;
          dmem_we_d    = dec_is_store;
          state_d      = ST_MEM;
        end else if (dec_is_alu) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (dec_is_store) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (dec_is_load) begin
          acc_d   = dmem_rdata;
          z_d     = (dmem_rdata == 16'h0000);
          state_d = ST_FETCH;
        end else if (dec_is_alu) begin
          alu_in1_d = acc_q;
          if (dec_uses_mem) begin
            alu_in2_d = dmem_rdata;
          end else begin
            alu_in2_d = 16'h0000;
          end
          alu_sel_d = dec_alu_sel;
          state_d   = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        acc_d   = alu_out;
        z_d     = alu_zf;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Instruction address tracks the PC it will fetch next (frozen in HALT)
  always_comb begin
    imem_addr_d = pc_d;
  end

  // State and output registers; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= 16'h0000;
      acc_q        <= 16'h0000;
      z_q          <= 1'b0;
      halted_q     <= 1'b0;
      imem_addr_q  <= RESET_PC;
      dmem_addr_q  <= {AW{1'b0}};
      dmem_wdata_q <= 16'h0000;
      dmem_we_q    <= 1'b0;
      alu_in1_q    <= 16'h0000;
      alu_in2_q    <= 16'h0000;
      alu_sel_q    <= ALU_PASS1;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      acc_q        <= acc_d;
      z_q          <= z_d;
      halted_q     <= halted_d;
      imem_addr_q  <= imem_addr_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      alu_sel_q    <= alu_sel_d;
    end
  end

  assign imem_addr  = imem_addr_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_we    = dmem_we_q;
  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign alu_sel    = alu_sel_q;
  assign acc        = acc_q;
  assign pc         = pc_q;
  assign halted     = halted_q;

endmodule
